// File: rtl/smash_lane_arbiter.sv
// Round-robin output-lane arbiter for the SMASH NoC router: five requesters share
// one lane, and the winning flit is held in a single-entry valid/ready output register.
module smash_lane_arbiter #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 32,
  localparam int FLIT_W = 2 * ADDR_SIZE + DATA_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4:0]            i_req,
  input  logic [5*FLIT_W-1:0]   i_flits,
  output logic [4:0]            o_grant,
  output logic                  o_valid,
  output logic [FLIT_W-1:0]     o_flit,
  output logic [2:0]            o_src_dir,
  input  logic                  i_ready,
  input  logic                  i_clr_cnt,
  output logic [15:0]           o_flit_cnt
);

  logic [2:0]        ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [2:0]        src_q, src_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [2:0]        ptr_eff_s;
  logic [3:0]        sum_s;
  logic [2:0]        idx_s;
  logic              found_s;
  logic [2:0]        win_s;
  logic              can_accept_s;
  logic              granted_s;
  logic [4:0]        grant_s;
  logic [FLIT_W-1:0] win_flit_s;

  // Rotating priority search starting at the pointer; out-of-range pointers act as 0.
  always_comb begin
    ptr_eff_s = (ptr_q > 3'd4) ? 3'd0 : ptr_q;
    found_s   = 1'b0;
    win_s     = 3'd0;
    sum_s     = 4'd0;
    idx_s     = 3'd0;
    for (int i = 0; i < 5; i++) begin
      sum_s   = {1'b0, ptr_eff_s} + 4'(i);
      idx_s   = (sum_s >= 4'd5) ? 3'(sum_s - 4'd5) : sum_s[2:0];
      win_s   = (!found_s && i_req[idx_s]) ? idx_s : win_s;
      found_s = found_s | i_req[idx_s];
    end
    can_accept_s = !valid_q || i_ready;
    granted_s    = i_rst && can_accept_s && found_s;
    grant_s      = granted_s ? (5'b00001 << win_s) : 5'b00000;
  end

  always_comb begin
    case (win_s)
      3'd0:    win_flit_s = i_flits[0*FLIT_W +: FLIT_W];
      3'd1:    win_flit_s = i_flits[1*FLIT_W +: FLIT_W];
      3'd2:    win_flit_s = i_flits[2*FLIT_W +: FLIT_W];
      3'd3:    win_flit_s = i_flits[3*FLIT_W +: FLIT_W];
      3'd4:    win_flit_s = i_flits[4*FLIT_W +: FLIT_W];
      default: win_flit_s = '0;
    endcase
  end

  // Output register load/pop, pointer advance and saturating grant counter.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    flit_d  = flit_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    if (granted_s) begin
      flit_d  = win_flit_s;
      src_d   = win_s;
      valid_d = 1'b1;
      ptr_d   = (win_s == 3'd4) ? 3'd0 : win_s + 3'd1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
      src_d   = 3'd7;
    end else begin
      valid_d = valid_q;
    end
    if (i_clr_cnt) begin
      cnt_d = 16'd0;
    end else if (granted_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ptr_q   <= 3'd0;
      valid_q <= 1'b0;
      flit_q  <= '0;
      src_q   <= 3'd7;
      cnt_q   <= 16'd0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant    = grant_s;
  assign o_valid    = valid_q;
  assign o_flit     = flit_q;
  assign o_src_dir  = src_q;
  assign o_flit_cnt = cnt_q;

endmodule

// File: tb/tb_smash_lane_arbiter.sv
// Directed, table-driven bench for smash_lane_arbiter with hand sequences for
// sustained backpressure and counter saturation.
module tb_smash_lane_arbiter;

  localparam int FW = 40;

  logic              i_clk;
  logic              i_rst;
  logic [4:0]        i_req;
  logic [5*FW-1:0]   i_flits;
  logic [4:0]        o_grant;
  logic              o_valid;
  logic [FW-1:0]     o_flit;
  logic [2:0]        o_src_dir;
  logic              i_ready;
  logic              i_clr_cnt;
  logic [15:0]       o_flit_cnt;

  logic [FW-1:0] flits [5];
  assign i_flits = {flits[4], flits[3], flits[2], flits[1], flits[0]};

  smash_lane_arbiter #(.ADDR_SIZE(4), .DATA_SIZE(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_flits(i_flits),
    .o_grant(o_grant), .o_valid(o_valid), .o_flit(o_flit), .o_src_dir(o_src_dir),
    .i_ready(i_ready), .i_clr_cnt(i_clr_cnt), .o_flit_cnt(o_flit_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic          rst;
    logic [4:0]    req;
    logic          rdy;
    logic          clr;
    logic [4:0]    g;
    logic          v;
    logic [2:0]    src;
    logic [FW-1:0] flit;
    logic [15:0]   cnt;
  } vec_t;

  vec_t tbl[$];
  int n_pass;
  int n_total;

  localparam logic [FW-1:0] F0 = 40'h11;
  localparam logic [FW-1:0] F1 = 40'h22;
  localparam logic [FW-1:0] F2 = 40'h33;
  localparam logic [FW-1:0] F3 = 40'h44;
  localparam logic [FW-1:0] F4 = 40'h55;
  localparam logic [FW-1:0] FA = 40'hC3_A5A5_0001;

  function automatic vec_t mk(logic rst, logic [4:0] req, logic rdy, logic clr,
                              logic [4:0] g, logic v, logic [2:0] src,
                              logic [FW-1:0] flit, logic [15:0] cnt);
    vec_t r;
    r.rst = rst; r.req = req; r.rdy = rdy; r.clr = clr;
    r.g = g; r.v = v; r.src = src; r.flit = flit; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, check combinational grant, then the registered state.
  task automatic apply(input vec_t v, input int idx);
    @(negedge i_clk);
    i_rst = v.rst; i_req = v.req; i_ready = v.rdy; i_clr_cnt = v.clr;
    #1;
    chk($sformatf("grant[%0d]", idx), 64'(o_grant), 64'(v.g));
    @(posedge i_clk);
    #1;
    chk($sformatf("valid[%0d]", idx), 64'(o_valid), 64'(v.v));
    chk($sformatf("src[%0d]", idx), 64'(o_src_dir), 64'(v.src));
    chk($sformatf("flit[%0d]", idx), 64'(o_flit), 64'(v.flit));
    chk($sformatf("cnt[%0d]", idx), 64'(o_flit_cnt), 64'(v.cnt));
  endtask

  int split;
  logic grant_ok;

  initial begin
    n_pass = 0; n_total = 0;
    i_rst = 1'b0; i_req = 5'h1F; i_ready = 1'b1; i_clr_cnt = 1'b0;
    flits[0] = F0; flits[1] = F1; flits[2] = F2; flits[3] = F3; flits[4] = F4;

    // reset with everyone requesting
    tbl.push_back(mk(1'b0, 5'h1F, 1'b1, 1'b0, 5'h00, 1'b0, 3'd7, '0, 16'd0));
    tbl.push_back(mk(1'b0, 5'h1F, 1'b1, 1'b0, 5'h00, 1'b0, 3'd7, '0, 16'd0));
    // rotation with pass-through
    tbl.push_back(mk(1'b1, 5'h1F, 1'b1, 1'b0, 5'h01, 1'b1, 3'd0, F0, 16'd1));
    tbl.push_back(mk(1'b1, 5'h1F, 1'b1, 1'b0, 5'h02, 1'b1, 3'd1, F1, 16'd2));
    tbl.push_back(mk(1'b1, 5'h1F, 1'b1, 1'b0, 5'h04, 1'b1, 3'd2, F2, 16'd3));
    tbl.push_back(mk(1'b1, 5'h1F, 1'b1, 1'b0, 5'h08, 1'b1, 3'd3, F3, 16'd4));
    tbl.push_back(mk(1'b1, 5'h1F, 1'b1, 1'b0, 5'h10, 1'b1, 3'd4, F4, 16'd5));
    tbl.push_back(mk(1'b1, 5'h1F, 1'b1, 1'b0, 5'h01, 1'b1, 3'd0, F0, 16'd6));
    // drain, then a grant under backpressure
    tbl.push_back(mk(1'b1, 5'h00, 1'b1, 1'b0, 5'h00, 1'b0, 3'd7, F0, 16'd6));
    tbl.push_back(mk(1'b1, 5'h02, 1'b0, 1'b0, 5'h02, 1'b1, 3'd1, F1, 16'd7));
    split = tbl.size();
    // release: same-cycle pop and new grant of right's new flit
    tbl.push_back(mk(1'b1, 5'h02, 1'b1, 1'b0, 5'h02, 1'b1, 3'd1, FA, 16'd8));
    // wrap/skip: down sets ptr=3, then up wins over down, then down
    tbl.push_back(mk(1'b1, 5'h04, 1'b1, 1'b0, 5'h04, 1'b1, 3'd2, F2, 16'd9));
    tbl.push_back(mk(1'b1, 5'h05, 1'b1, 1'b0, 5'h01, 1'b1, 3'd0, F0, 16'd10));
    tbl.push_back(mk(1'b1, 5'h05, 1'b1, 1'b0, 5'h04, 1'b1, 3'd2, F2, 16'd11));
    // clear has priority over a coincident increment
    tbl.push_back(mk(1'b1, 5'h01, 1'b1, 1'b1, 5'h01, 1'b1, 3'd0, F0, 16'd0));
    // mid-operation reset while stalled, then up wins first
    tbl.push_back(mk(1'b1, 5'h08, 1'b0, 1'b0, 5'h00, 1'b1, 3'd0, F0, 16'd0));
    tbl.push_back(mk(1'b0, 5'h08, 1'b0, 1'b0, 5'h00, 1'b0, 3'd7, '0, 16'd0));
    tbl.push_back(mk(1'b1, 5'h1F, 1'b1, 1'b0, 5'h01, 1'b1, 3'd0, F0, 16'd1));

    for (int i = 0; i < split; i++) apply(tbl[i], i);

    // held stable for 10 cycles under backpressure; the right flit changes meanwhile
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      i_req = 5'h02; i_ready = 1'b0; i_clr_cnt = 1'b0;
      if (c == 5) flits[1] = FA;
      #1;
      chk($sformatf("bp_grant[%0d]", c), 64'(o_grant), 64'h0);
      @(posedge i_clk);
      #1;
      chk($sformatf("bp_flit[%0d]", c), 64'(o_flit), 64'(F1));
      chk($sformatf("bp_src[%0d]", c), 64'(o_src_dir), 64'd1);
      chk($sformatf("bp_valid[%0d]", c), 64'(o_valid), 64'd1);
    end

    for (int i = split; i < tbl.size(); i++) apply(tbl[i], i);

    // counter saturation: clear, then 65537 back-to-back grants to up
    @(negedge i_clk);
    i_req = 5'h00; i_ready = 1'b1; i_clr_cnt = 1'b1;
    @(posedge i_clk);
    #1;
    chk("sat_clr", 64'(o_flit_cnt), 64'd0);
    grant_ok = 1'b1;
    for (int n = 1; n <= 65537; n++) begin
      @(negedge i_clk);
      i_req = 5'h01; i_ready = 1'b1; i_clr_cnt = 1'b0;
      #1;
      if (o_grant !== 5'h01) grant_ok = 1'b0;
      @(posedge i_clk);
      #1;
      if (n == 65534) chk("sat_fffe", 64'(o_flit_cnt), 64'hFFFE);
      if (n == 65535) chk("sat_ffff", 64'(o_flit_cnt), 64'hFFFF);
    end
    chk("sat_grants", 64'(grant_ok), 64'd1);
    chk("sat_hold", 64'(o_flit_cnt), 64'hFFFF);
    apply(mk(1'b1, 5'h01, 1'b1, 1'b1, 5'h01, 1'b1, 3'd0, F0, 16'd0), 99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
